// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES core scheduler.
// The DELAY state exists only when RAND_START_DELAY_EN is defined.
package aes_sched_pkg;
    localparam int BLK_W = 128;
    localparam int KEY_W = 256;
    localparam int ID_W  = 1;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

`ifdef RAND_START_DELAY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_DELAY, ST_LOAD, ST_RUN, ST_RESP} state_e;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_RESP} state_e;
`endif
endpackage

// File: rtl/aes_core_scheduler_if.sv
// Request (two ports) and tagged response channels of the scheduler.
interface aes_core_scheduler_if;
    import aes_sched_pkg::*;

    logic               req0_valid, req1_valid;
    logic               req0_ready, req1_ready;
    logic [BLK_W-1:0]   req0_plain, req1_plain;
    logic [KEY_W-1:0]   req0_key, req1_key;
    logic               resp_valid, resp_ready;
    logic [ID_W-1:0]    resp_id;
    logic [BLK_W-1:0]   resp_cipher;
    logic               resp_fault, resp_timeout;

    modport slave (
        input  req0_valid, req1_valid, req0_plain, req1_plain, req0_key, req1_key, resp_ready,
        output req0_ready, req1_ready, resp_valid, resp_id, resp_cipher, resp_fault, resp_timeout
    );
    modport master (
        output req0_valid, req1_valid, req0_plain, req1_plain, req0_key, req1_key, resp_ready,
        input  req0_ready, req1_ready, resp_valid, resp_id, resp_cipher, resp_fault, resp_timeout
    );
endinterface

// File: rtl/aes_sched_rr_arb.sv
// Two-way round-robin grant; the last-grant pointer moves only on a handshake.
module aes_sched_rr_arb
    import aes_sched_pkg::*;
(
    input  logic            Clk,
    input  logic            Reset,
    input  logic [1:0]      valid,
    input  logic            advance,
    output logic [ID_W-1:0] gnt_id
);
    logic [ID_W-1:0] last_q, last_d;

    always_comb begin
        gnt_id = '0;
        if (valid == 2'b11)
            gnt_id = ~last_q;
        else if (valid[1])
            gnt_id = ID_W'(1);
        last_d = advance ? gnt_id : last_q;
    end

    // "last granted = 1" out of reset so requester 0 wins the first tie
    always_ff @(posedge Clk) begin
        if (Reset) last_q <= ID_W'(1);
        else       last_q <= last_d;
    end
endmodule

// File: rtl/aes_core_scheduler.sv
// Shares one dual-rail AES-256 core between two requesters, checks rail complementarity.
// Optional start jitter via LFSR-driven DELAY state when RAND_START_DELAY_EN is defined.
module aes_core_scheduler
    import aes_sched_pkg::*;
#(
    parameter int LOAD_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int FCNT_W         = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    aes_core_scheduler_if.slave bus,
    output logic                core_Reset,
    output logic [BLK_W-1:0]    core_Plain_T,
    output logic [KEY_W-1:0]    core_Key_T,
    input  logic [BLK_W-1:0]    core_Cipher_T,
    input  logic [BLK_W-1:0]    core_Cipher_F,
    input  logic                core_Done,
    output logic                busy,
    output logic                trigger,
    output logic [FCNT_W-1:0]   fault_count
);
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 4) ? $clog2(TIMEOUT_CYCLES) : 4;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BLK_W-1:0]   plain_q, plain_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    resp_id_q, resp_id_d;
    logic [BLK_W-1:0]   resp_cipher_q, resp_cipher_d;
    logic               resp_fault_q, resp_fault_d;
    logic               resp_timeout_q, resp_timeout_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
    logic [ID_W-1:0]    gnt_id;
    logic               hs;

`ifdef RAND_START_DELAY_EN
    logic [15:0] lfsr_q, lfsr_d;
    assign lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
`endif

    assign hs = (state_q == ST_IDLE) && (bus.req0_valid || bus.req1_valid);

    aes_sched_rr_arb u_arb (
        .Clk     (Clk),
        .Reset   (Reset),
        .valid   ({bus.req1_valid, bus.req0_valid}),
        .advance (hs),
        .gnt_id  (gnt_id)
    );

    assign bus.req0_ready   = hs && (gnt_id == '0);
    assign bus.req1_ready   = hs && (gnt_id == ID_W'(1));
    assign bus.resp_valid   = (state_q == ST_RESP);
    assign bus.resp_id      = resp_id_q;
    assign bus.resp_cipher  = resp_cipher_q;
    assign bus.resp_fault   = resp_fault_q;
    assign bus.resp_timeout = resp_timeout_q;
    assign core_Reset       = (state_q != ST_RUN);
    assign trigger          = (state_q == ST_RUN);
    assign busy             = (state_q != ST_IDLE);
    assign core_Plain_T     = plain_q;
    assign core_Key_T       = key_q;
    assign fault_count      = fcnt_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        plain_d        = plain_q;
        key_d          = key_q;
        id_d           = id_q;
        resp_id_d      = resp_id_q;
        resp_cipher_d  = resp_cipher_q;
        resp_fault_d   = resp_fault_q;
        resp_timeout_d = resp_timeout_q;
        fcnt_d         = fcnt_q;
        case (state_q)
            ST_IDLE: if (hs) begin
                plain_d = (gnt_id == ID_W'(1)) ? bus.req1_plain : bus.req0_plain;
                key_d   = (gnt_id == ID_W'(1)) ? bus.req1_key   : bus.req0_key;
                id_d    = gnt_id;
                cnt_d   = '0;
                state_d = ST_LOAD;
`ifdef RAND_START_DELAY_EN
                if (lfsr_q[3:0] != 4'd0) begin
                    cnt_d   = CNT_W'(lfsr_q[3:0]);
                    state_d = ST_DELAY;
                end
            end
            // counts down from the sampled delay; LOAD follows the last DELAY cycle
            ST_DELAY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                end
`endif
            end
            ST_LOAD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(LOAD_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            // Done is checked before the timeout so a Done in the last cycle still wins
            ST_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (core_Done) begin
                    resp_id_d      = id_q;
                    resp_timeout_d = 1'b0;
                    if (core_Cipher_F == ~core_Cipher_T) begin
                        resp_cipher_d = core_Cipher_T;
                        resp_fault_d  = 1'b0;
                    end else begin
                        resp_cipher_d = '0;
                        resp_fault_d  = 1'b1;
                        if (fcnt_q != '1) fcnt_d = fcnt_q + 1'b1;
                    end
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    resp_id_d      = id_q;
                    resp_cipher_d  = '0;
                    resp_fault_d   = 1'b0;
                    resp_timeout_d = 1'b1;
                    state_d        = ST_RESP;
                end
            end
            ST_RESP: if (bus.resp_ready) begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            plain_q        <= '0;
            key_q          <= '0;
            id_q           <= '0;
            resp_id_q      <= '0;
            resp_cipher_q  <= '0;
            resp_fault_q   <= 1'b0;
            resp_timeout_q <= 1'b0;
            fcnt_q         <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            plain_q        <= plain_d;
            key_q          <= key_d;
            id_q           <= id_d;
            resp_id_q      <= resp_id_d;
            resp_cipher_q  <= resp_cipher_d;
            resp_fault_q   <= resp_fault_d;
            resp_timeout_q <= resp_timeout_d;
            fcnt_q         <= fcnt_d;
        end
    end

`ifdef RAND_START_DELAY_EN
    always_ff @(posedge Clk) begin
        if (Reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_d;
    end
`endif
endmodule

// File: tb/tb_aes_core_scheduler.sv
// Directed bench for aes_core_scheduler with a behavioural dual-rail core and a response scoreboard.
module tb_aes_core_scheduler;
    localparam int LOAD_CYCLES    = 2;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int FCNT_W         = 4;

    localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] PT1 = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    typedef struct {
        logic         id;
        logic [127:0] cipher;
        logic         fault;
        logic         timeout;
    } exp_t;

    logic               Clk = 1'b0;
    logic               Reset;
    logic               core_Reset, core_Done, busy, trigger;
    logic [127:0]       core_Plain_T, core_Cipher_T, core_Cipher_F;
    logic [255:0]       core_Key_T;
    logic [FCNT_W-1:0]  fault_count;

    int   checks = 0;
    int   errors = 0;
    int   done_lat = 3;
    bit   flip = 1'b0;
    bit   done_force = 1'b0;
    int   run_cyc = 0;
    exp_t sb[$];

    aes_core_scheduler_if bus ();

    aes_core_scheduler #(
        .LOAD_CYCLES(LOAD_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .FCNT_W(FCNT_W)
    ) dut (
        .Clk(Clk), .Reset(Reset), .bus(bus),
        .core_Reset(core_Reset), .core_Plain_T(core_Plain_T), .core_Key_T(core_Key_T),
        .core_Cipher_T(core_Cipher_T), .core_Cipher_F(core_Cipher_F), .core_Done(core_Done),
        .busy(busy), .trigger(trigger), .fault_count(fault_count)
    );

    always #5 Clk = ~Clk;

    // core model: Done after done_lat run cycles (negative = never), optional rail corruption
    always @(posedge Clk) run_cyc <= core_Reset ? 0 : run_cyc + 1;
    assign core_Done     = done_force | (!core_Reset && done_lat >= 0 && run_cyc == done_lat);
    assign core_Cipher_T = CT;
    assign core_Cipher_F = ~CT ^ (flip ? 128'h20 : 128'h0);

`ifdef RAND_START_DELAY_EN
    logic [15:0] m_lfsr;
    always @(posedge Clk)
        if (Reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic txn(input int id, input bit both, input int hold);
        exp_t e;
        int pre, run_n, exp_pre, exp_run;
        bit got;
        logic [127:0] pt;
        pt = (id == 1) ? PT1 : PT0;
        @(negedge Clk);
        if (both) begin
            bus.req0_valid = 1'b1;
            bus.req1_valid = 1'b1;
        end else if (id == 0) bus.req0_valid = 1'b1;
        else bus.req1_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            #1;
            if (bus.req0_ready || bus.req1_ready) got = 1'b1;
            else @(negedge Clk);
        end
        chk("grant_seen", got, 1);
        if (!got) return;
        chk("grant_req0", bus.req0_ready, id == 0);
        chk("grant_req1", bus.req1_ready, id == 1);
        exp_pre = LOAD_CYCLES;
`ifdef RAND_START_DELAY_EN
        exp_pre += int'(m_lfsr[3:0]);
`endif
        e.id      = (id == 1);
        e.timeout = (done_lat < 0) || (done_lat >= TIMEOUT_CYCLES);
        e.fault   = flip && !e.timeout;
        e.cipher  = (e.fault || e.timeout) ? 128'h0 : CT;
        exp_run   = e.timeout ? TIMEOUT_CYCLES : done_lat + 1;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        if (!both) begin
            if (id == 0) bus.req0_valid = 1'b0;
            else bus.req1_valid = 1'b0;
        end
        pre = 0; run_n = 0; got = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge Clk);
            if (i == 0) begin
                chk("plain_latched", core_Plain_T, pt);
                chk("key_latched", core_Key_T, KEY);
            end
            if (bus.resp_valid) begin
                got = 1'b1;
                break;
            end
            if (trigger) run_n++;
            else if (core_Reset && busy) pre++;
        end
        chk("resp_seen", got, 1);
        if (!got) return;
        chk("pre_run_cycles", pre, exp_pre);
        chk("run_cycles", run_n, exp_run);
        e = sb.pop_front();
        for (int i = 0; i <= hold; i++) begin
            chk("resp_valid", bus.resp_valid, 1);
            chk("resp_id", bus.resp_id, e.id);
            chk("resp_cipher", bus.resp_cipher, e.cipher);
            chk("resp_fault", bus.resp_fault, e.fault);
            chk("resp_timeout", bus.resp_timeout, e.timeout);
            if (hold > 0) chk("no_grant_in_resp", bus.req0_ready | bus.req1_ready, 0);
            if (i < hold) @(negedge Clk);
        end
        bus.resp_ready = 1'b1;
        @(posedge Clk);
        #1;
        bus.resp_ready = 1'b0;
        chk("resp_valid_drop", bus.resp_valid, 0);
        chk("resp_cipher_hold", bus.resp_cipher, e.cipher);
    endtask

    initial begin
        int seen;
        bit got;
        Reset = 1'b1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_plain = PT0;  bus.req1_plain = PT1;
        bus.req0_key = KEY;    bus.req1_key = KEY;
        bus.resp_ready = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_core_reset", core_Reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_trigger", trigger, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_fault_count", fault_count, 0);
        chk("rst_key", core_Key_T, 0);
        chk("rst_ready", bus.req0_ready | bus.req1_ready, 0);
        Reset = 1'b0;

        // known-answer transaction, core_Reset low from cycle 3 to Done
        done_lat = 3;
        txn(0, 1'b0, 0);

        // round-robin from a fresh reset: 0,1,0,1
        @(negedge Clk); Reset = 1'b1;
        @(posedge Clk); #1; Reset = 1'b0;
        done_lat = 1;
        for (int k = 0; k < 4; k++) txn(k % 2, 1'b1, 0);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

        // back-pressure: response held 10 cycles while req1 waits
        done_lat = 0;
        txn(0, 1'b1, 10);
        txn(1, 1'b1, 0);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

        // rail mismatch and counter saturation
        flip = 1'b1;
        txn(0, 1'b0, 0);
        chk("fault_count_one", fault_count, 1);
        for (int k = 0; k < 16; k++) txn(0, 1'b0, 0);
        chk("fault_count_sat", fault_count, {FCNT_W{1'b1}});
        flip = 1'b0;

        // timeout, then Done on the final allowed cycle
        done_lat = -1;
        txn(0, 1'b0, 0);
        done_lat = TIMEOUT_CYCLES - 1;
        txn(1, 1'b0, 0);

        // reset during RUN aborts without a response
        done_lat = -1;
        @(negedge Clk); bus.req0_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge Clk);
            if (trigger) got = 1'b1;
            bus.req0_valid = 1'b0;
        end
        chk("abort_run_reached", got, 1);
        Reset = 1'b1;
        @(posedge Clk); #1;
        chk("abort_busy", busy, 0);
        chk("abort_core_reset", core_Reset, 1);
        chk("abort_trigger", trigger, 0);
        chk("abort_resp_valid", bus.resp_valid, 0);
        chk("abort_plain", core_Plain_T, 0);
        Reset = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge Clk);
            if (bus.resp_valid) seen++;
        end
        chk("abort_no_resp", seen, 0);

        // Done outside RUN is ignored
        done_force = 1'b1;
        repeat (3) @(negedge Clk);
        chk("idle_done_busy", busy, 0);
        chk("idle_done_resp", bus.resp_valid, 0);
        done_force = 1'b0;

        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes_core_scheduler.md
Name: aes_core_scheduler

Overview:
- Sequences and shares one dual-rail AES-256 encryption core between two requesters (host port 0, self-test/verify port 1).
- Arbitrates round-robin and latches plaintext/key; drives the core's reset-as-start protocol; waits for Done with a timeout.
- Checks dual-rail complementarity (Cipher_F == ~Cipher_T) and returns tagged results over a valid/ready channel.
- Drives the scope trigger while the core runs.

Parameters:
LOAD_CYCLES, 2, cycles core_Reset is held high with operands stable before start (1..15)
TIMEOUT_CYCLES, 4096, max RUN cycles before abort (≥2)
FCNT_W, 16, width of saturating fault counter

Ports:
Clk  in  1  single clock, all logic rising-edge
Reset  in  1  synchronous, active-high
req0_valid / req1_valid  in  1  request present
req0_ready / req1_ready  out  1  request accepted this cycle
req0_plain / req1_plain  in  128  plaintext, true rail
req0_key / req1_key  in  256  key, true rail
resp_valid  out  1  result present
resp_ready  in  1  consumer accepts result
resp_id  out  1  requester index of result
resp_cipher  out  128  ciphertext (zero on fault/timeout)
resp_fault  out  1  dual-rail mismatch detected
resp_timeout  out  1  core_Done not seen in time
core_Reset  out  1  core reset/start; high = hold/load
core_Plain_T  out  128  latched plaintext to core
core_Key_T  out  256  latched key to core
core_Cipher_T  in  128  core output, true rail
core_Cipher_F  in  128  core output, false rail
core_Done  in  1  core completion
busy  out  1  state != IDLE
trigger  out  1  high exactly while state == RUN
fault_count  out  FCNT_W  saturating count of faulted results

Behaviour:
- States IDLE, [DELAY], LOAD, RUN, RESP. Reset (sync) → IDLE; core_Reset=1, ready/resp_valid/resp_*=0, core operands 0, fault_count=0, rr pointer favours req0, counters 0.
- IDLE: reqN_ready is combinational, asserted only for the granted requester. Grant = sole valid requester, or if both valid, the one not granted last. On handshake: latch plain/key/id, update pointer, go LOAD (or DELAY with the option).
- LOAD: core_Reset=1, operands stable for exactly LOAD_CYCLES cycles → RUN.
- RUN: core_Reset=0, trigger=1, cycle counter increments. core_Done sampled every RUN cycle including the first.
  - Done seen: if core_Cipher_F == ~core_Cipher_T, capture cipher, fault=0; else cipher=0, fault=1, fault_count+1 saturating at all-ones. → RESP.
  - Counter reaches TIMEOUT_CYCLES without Done: cipher=0, timeout=1 → RESP.
  - Done in the timeout cycle wins; timeout=0.
- RESP: core_Reset=1, resp_valid=1, resp_* stable until resp_valid&resp_ready → IDLE. resp_* hold the last value after the handshake.
- Latency without option: request accepted cycle 0, core_Reset falls at cycle LOAD_CYCLES+1, resp_valid rises the cycle after Done is sampled. Back-to-back requests: the next acceptance is possible the cycle after the response handshake.
- Requests arriving while busy wait (ready=0); valid may drop without penalty.
- Reset asserted mid-operation aborts immediately to reset values; no response is issued for the in-flight request.
- core_Done outside RUN is ignored.

Optional Feature:
- Macro RAND_START_DELAY_EN.
- Defined: 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 on Reset, advances every cycle). On acceptance, go to DELAY for lfsr[3:0] cycles (0 = straight to LOAD next cycle), core_Reset=1, trigger=0. This adds jitter against trace alignment.
- Undefined: no LFSR, no DELAY state; IDLE→LOAD directly.

Decomposition:
- Package aes_sched_pkg: state enum, BLK_W=128, KEY_W=256, LFSR seed/tap constants, ID width.
- One sub-module aes_sched_rr_arb: 2-way round-robin grant with registered last-grant pointer, advanced on handshake.

Test Plan:
- req0 key 000102..1f, pt 00112233445566778899aabbccddeeff; core model returns 8ea2b7ca516745bfeafc49904b496089 with F=~T → resp_id=0, cipher matches, fault=0. core_Reset low exactly cycles 3..(Done) with LOAD_CYCLES=2.
- req0 and req1 valid same cycle, repeated 4 requests → grants alternate 0,1,0,1; first grant 0 after reset.
- Model flips F bit 5 → resp_fault=1, cipher=0, fault_count=1. Force 0xFFFF+1 faults → fault_count stays 0xFFFF.
- Core never asserts Done, TIMEOUT_CYCLES=16 → resp_timeout=1 after 16 RUN cycles. Done on 16th cycle → normal result, timeout=0.
- resp_ready held low 10 cycles → resp_* stable, no new grant. Reset pulsed during RUN → next cycle IDLE, core_Reset=1, no response.
- With RAND_START_DELAY_EN: first request delay equals lfsr[3:0] from seed sequence; trigger low during DELAY.
